// File: rtl/tty_uart_ctl.sv
// KL8E-style teletype controller: decodes keyboard/printer IOTs and sequences
// the byte UART receive and transmit handshakes.
module tty_uart_ctl #(
  parameter logic [5:0] KBD_DEV = 6'o03,
  parameter logic [5:0] PRT_DEV = 6'o04
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iot,
  input  logic [5:0] io_select,
  input  logic [2:0] io_op,
  input  logic [7:0] io_data_in,
  output logic [7:0] io_data_out,
  output logic       io_data_out_en,
  output logic       io_clear_ac,
  output logic       io_skip,
  output logic       interrupt_req,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_ack,
  input  logic       tx_empty,
  output logic       rx_req,
  input  logic       rx_ack,
  input  logic       rx_empty,
  input  logic [7:0] rx_data
);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_REQ   = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_LATCH = 2'd3;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_REQ  = 2'd1;
  localparam logic [1:0] T_ACK  = 2'd2;
  localparam logic [1:0] T_BUSY = 2'd3;

  logic [1:0] rx_state, rx_next;
  logic [1:0] tx_state, tx_next;
  logic       kbd_flag, prt_flag, ie, tx_pending;
  logic [7:0] kbd_buf, prt_buf;

  logic kbd_sel, prt_sel;
  logic kbd_clr, kbd_ie_wr, prt_set, prt_clr, prt_load;
  logic rx_latch, tx_accept, tx_done;

  assign kbd_sel = iot && (io_select == KBD_DEV);
  assign prt_sel = iot && (io_select == PRT_DEV);

  assign kbd_clr   = kbd_sel && (io_op == 3'd0 || io_op == 3'd2 || io_op == 3'd6);
  assign kbd_ie_wr = kbd_sel && (io_op == 3'd5);
  assign prt_set   = prt_sel && (io_op == 3'd0);
  assign prt_clr   = prt_sel && (io_op == 3'd2 || io_op == 3'd6);
  assign prt_load  = prt_sel && (io_op == 3'd4 || io_op == 3'd6);

  assign rx_latch  = (rx_state == R_LATCH);
  assign tx_accept = (tx_state == T_REQ) && tx_ack;
  assign tx_done   = (tx_state == T_BUSY) && tx_empty;

  assign tx_data = prt_buf;

  // IOT bus responses are purely combinational in the strobe cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    io_skip        = 1'b0;
    io_clear_ac    = 1'b0;
    io_data_out    = 8'h00;
    io_data_out_en = 1'b0;
    if (kbd_sel) begin
      case (io_op)
        3'd1: io_skip = kbd_flag;
        3'd2: io_clear_ac = 1'b1;
        3'd4: begin
          io_data_out    = kbd_buf;
          io_data_out_en = 1'b1;
        end
        3'd6: begin
          io_clear_ac    = 1'b1;
          io_data_out    = kbd_buf;
          io_data_out_en = 1'b1;
        end
        default: ;
      endcase
    end else if (prt_sel) begin
      case (io_op)
        3'd1: io_skip = prt_flag;
        3'd5: io_skip = prt_flag | kbd_flag;
        default: ;
      endcase
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (!kbd_flag && !rx_empty) rx_next = R_REQ;
      R_REQ:   if (rx_ack) rx_next = R_WAIT;
      R_WAIT:  rx_next = R_LATCH;
      default: rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (tx_pending) tx_next = T_REQ;
      T_REQ:   if (tx_ack) tx_next = T_ACK;
      T_ACK:   tx_next = T_BUSY;
      default: if (tx_empty) tx_next = T_IDLE;
    endcase
  end

  // Requests are decoded from the next state so they leave a flop cleanly.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch only.
    if (reset) begin
      rx_state      <= R_IDLE;
      tx_state      <= T_IDLE;
      rx_req        <= 1'b0;
      tx_req        <= 1'b0;
      kbd_flag      <= 1'b0;
      prt_flag      <= 1'b0;
      ie            <= 1'b1;
      kbd_buf       <= 8'h00;
      prt_buf       <= 8'h00;
      tx_pending    <= 1'b0;
      interrupt_req <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rx_state      <= rx_next;
      tx_state      <= tx_next;
      rx_req        <= (rx_next == R_REQ);
      tx_req        <= (tx_next == T_REQ);
      interrupt_req <= ie & (kbd_flag | prt_flag);

      // Hardware set beats a clearing IOT in the same cycle.
      if (rx_latch)     kbd_flag <= 1'b1;
      else if (kbd_clr) kbd_flag <= 1'b0;
      if (rx_latch)     kbd_buf <= rx_data;

      if (tx_done || prt_set) prt_flag <= 1'b1;
      else if (prt_clr)       prt_flag <= 1'b0;

      if (kbd_ie_wr) ie <= io_data_in[0];

      if (prt_load) begin
        prt_buf    <= io_data_in;
        tx_pending <= 1'b1;
      end else if (tx_accept) begin
        tx_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tty_uart_ctl.sv
// Directed bench for tty_uart_ctl: IOT decode table plus UART handshake,
// interrupt, overlap and mid-transfer reset sequences against a fake UART.
module tb_tty_uart_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       iot;
  logic [5:0] io_select;
  logic [2:0] io_op;
  logic [7:0] io_data_in;
  logic [7:0] io_data_out;
  logic       io_data_out_en, io_clear_ac, io_skip, interrupt_req;
  logic       tx_req, tx_ack, tx_empty;
  logic [7:0] tx_data;
  logic       rx_req, rx_ack, rx_empty;
  logic [7:0] rx_data;

  localparam logic [5:0] KBD = 6'o03;
  localparam logic [5:0] PRT = 6'o04;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  int         rx_ack_cnt = 0;
  int         tx_ack_cnt = 0;
  int         tx_busy    = 0;

  tty_uart_ctl dut (
    .clk(clk), .reset(reset), .iot(iot), .io_select(io_select), .io_op(io_op),
    .io_data_in(io_data_in), .io_data_out(io_data_out), .io_data_out_en(io_data_out_en),
    .io_clear_ac(io_clear_ac), .io_skip(io_skip), .interrupt_req(interrupt_req),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .tx_empty(tx_empty),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_empty(rx_empty), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  // Fake UART: acks a request in the same cycle it sees it; transmitter stays
  // busy for 20 cycles after accepting a byte.
  initial begin
    rx_ack = 1'b0; rx_empty = 1'b1; rx_data = 8'h00;
    tx_ack = 1'b0; tx_empty = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rx_ack = rx_req;
      if (rx_req && rx_q.size() > 0) begin
        rx_data = rx_q.pop_front();
        rx_ack_cnt++;
      end
      rx_empty = (rx_q.size() == 0);
      tx_ack = tx_req;
      if (tx_req) begin
        tx_log.push_back(tx_data);
        tx_ack_cnt++;
        tx_empty = 1'b0;
        tx_busy  = 20;
      end else if (tx_busy > 0) begin
        tx_busy--;
        if (tx_busy == 0) tx_empty = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One IOT cycle; outputs sampled mid-cycle, returns at posedge+2 with iot low.
  task automatic do_iot(input logic v, input logic [5:0] sel, input logic [2:0] op,
                        input logic [7:0] din, output logic skip, output logic clr,
                        output logic en, output logic [7:0] dout);
    iot = v; io_select = sel; io_op = op; io_data_in = din;
    #1;
    skip = io_skip; clr = io_clear_ac; en = io_data_out_en; dout = io_data_out;
    @(posedge clk);
    #2;
    iot = 1'b0; io_data_in = 8'h00;
  endtask

  task automatic iot_skip(input logic [5:0] sel, input logic [2:0] op, input logic [7:0] din,
                          output logic skip);
    logic c, e;
    logic [7:0] d;
    do_iot(1'b1, sel, op, din, skip, c, e, d);
  endtask

  typedef struct {
    logic       v;
    logic [5:0] sel;
    logic [2:0] op;
    logic [7:0] din;
    logic       skip;
    logic       clr;
    logic       en;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic s, c, e, seen, flag_seen, req_seen;
    logic [7:0] d;
    logic [7:0] start_chars[6];
    int polls;

    // Decode table starting from reset state (flags clear, kbd_buf 0, ie 1).
    vecs[0]  = '{1, KBD, 3'd1, 8'h00, 0, 0, 0, 8'h00};  // KSF, flag clear
    vecs[1]  = '{1, PRT, 3'd1, 8'h00, 0, 0, 0, 8'h00};  // TSF, flag clear
    vecs[2]  = '{1, PRT, 3'd0, 8'h00, 0, 0, 0, 8'h00};  // TFL sets prt_flag
    vecs[3]  = '{1, PRT, 3'd1, 8'h00, 1, 0, 0, 8'h00};  // TSF skips
    vecs[4]  = '{1, PRT, 3'd5, 8'h00, 1, 0, 0, 8'h00};  // TSK via prt_flag
    vecs[5]  = '{1, KBD, 3'd1, 8'h00, 0, 0, 0, 8'h00};  // KSF still clear
    vecs[6]  = '{0, PRT, 3'd1, 8'h00, 0, 0, 0, 8'h00};  // no strobe
    vecs[7]  = '{1, 6'o05, 3'd1, 8'h00, 0, 0, 0, 8'h00}; // other device
    vecs[8]  = '{1, KBD, 3'd2, 8'h00, 0, 1, 0, 8'h00};  // KCC
    vecs[9]  = '{1, KBD, 3'd4, 8'h00, 0, 0, 1, 8'h00};  // KRS
    vecs[10] = '{1, KBD, 3'd6, 8'h00, 0, 1, 1, 8'h00};  // KRB
    vecs[11] = '{1, KBD, 3'd3, 8'h00, 0, 0, 0, 8'h00};
    vecs[12] = '{1, KBD, 3'd7, 8'h00, 0, 0, 0, 8'h00};
    vecs[13] = '{1, PRT, 3'd3, 8'h00, 0, 0, 0, 8'h00};
    vecs[14] = '{1, PRT, 3'd7, 8'h00, 0, 0, 0, 8'h00};
    vecs[15] = '{1, KBD, 3'd5, 8'h01, 0, 0, 0, 8'h00};  // KIE keeps ie=1
    vecs[16] = '{1, PRT, 3'd1, 8'h00, 1, 0, 0, 8'h00};  // prt_flag survived
    vecs[17] = '{1, PRT, 3'd2, 8'h00, 0, 0, 0, 8'h00};  // TCF
    vecs[18] = '{1, PRT, 3'd5, 8'h00, 0, 0, 0, 8'h00};  // TSK, both clear

    start_chars[0] = 8'o123; start_chars[1] = 8'o124; start_chars[2] = 8'o101;
    start_chars[3] = 8'o122; start_chars[4] = 8'o124; start_chars[5] = 8'o015;

    reset = 1'b1; iot = 1'b0; io_select = 6'o00; io_op = 3'd0; io_data_in = 8'h00;
    ticks(3);
    reset = 1'b0;
    check("rst_skip", io_skip, 0);
    check("rst_clr", io_clear_ac, 0);
    check("rst_en", io_data_out_en, 0);
    check("rst_dout", io_data_out, 0);
    check("rst_irq", interrupt_req, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_rx_req", rx_req, 0);
    check("rst_tx_data", tx_data, 0);

    for (int i = 0; i < 19; i++) begin
      do_iot(vecs[i].v, vecs[i].sel, vecs[i].op, vecs[i].din, s, c, e, d);
      check($sformatf("vec%0d_skip", i), s, vecs[i].skip);
      check($sformatf("vec%0d_clr", i), c, vecs[i].clr);
      check($sformatf("vec%0d_en", i), e, vecs[i].en);
      check($sformatf("vec%0d_dout", i), d, vecs[i].dout);
    end

    // Interrupt lags the flag by one cycle and is masked by ie.
    iot_skip(PRT, 3'd0, 8'h00, s);
    check("irq_lag", interrupt_req, 0);
    tick();
    check("irq_set", interrupt_req, 1);
    iot_skip(KBD, 3'd5, 8'h00, s);
    ticks(2);
    check("irq_masked", interrupt_req, 0);
    iot_skip(PRT, 3'd2, 8'h00, s);
    iot_skip(PRT, 3'd0, 8'h00, s);
    ticks(3);
    check("irq_masked_newflag", interrupt_req, 0);
    iot_skip(PRT, 3'd2, 8'h00, s);
    iot_skip(KBD, 3'd5, 8'h01, s);
    ticks(2);
    check("irq_no_flags", interrupt_req, 0);

    // Single character receive.
    rx_ack_cnt = 0;
    rx_q.push_back(8'o123);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (rx_req) seen = 1'b1;
      else tick();
    end
    check("rx_req_seen", seen, 1);
    tick();
    check("rx_req_drop", rx_req, 0);
    ticks(2);
    check("rx_irq_before", interrupt_req, 0);
    iot_skip(KBD, 3'd1, 8'h00, s);
    check("rx_ksf", s, 1);
    check("rx_irq_4cyc", interrupt_req, 1);
    check("rx_ack_one", rx_ack_cnt, 1);
    do_iot(1'b1, KBD, 3'd6, 8'h00, s, c, e, d);
    check("krb_clr", c, 1);
    check("krb_en", e, 1);
    check("krb_dout", d, 8'o123);
    iot_skip(KBD, 3'd1, 8'h00, s);
    check("krb_flag_clr", s, 0);
    check("krb_irq_clr", interrupt_req, 0);

    // "START\r" through a KSF/KRB loop; nothing fetched while the flag is up.
    rx_ack_cnt = 0;
    for (int i = 0; i < 6; i++) rx_q.push_back(start_chars[i]);
    for (int i = 0; i < 6; i++) begin
      s = 1'b0;
      for (int k = 0; k < 30 && !s; k++) iot_skip(KBD, 3'd1, 8'h00, s);
      check($sformatf("start%0d_flag", i), s, 1);
      ticks(5);
      check($sformatf("start%0d_no_overrun", i), rx_ack_cnt, i + 1);
      do_iot(1'b1, KBD, 3'd6, 8'h00, s, c, e, d);
      check($sformatf("start%0d_byte", i), d, start_chars[i]);
    end
    ticks(10);
    check("start_acks", rx_ack_cnt, 6);
    check("start_rx_idle", rx_req, 0);

    // TLS: clears prt_flag, sends the byte, flag returns once UART is idle.
    tx_ack_cnt = 0;
    tx_log.delete();
    iot_skip(PRT, 3'd0, 8'h00, s);
    iot_skip(PRT, 3'd6, 8'h41, s);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (tx_req) seen = 1'b1;
      else tick();
    end
    check("tls_tx_req", seen, 1);
    check("tls_tx_data", tx_data, 8'h41);
    s = 1'b0;
    polls = 0;
    for (int k = 0; k < 60 && !s; k++) begin
      iot_skip(PRT, 3'd1, 8'h00, s);
      polls++;
    end
    check("tls_flag_rise", s, 1);
    check("tls_flag_not_early", int'(polls >= 15), 1);
    check("tls_acks", tx_ack_cnt, 1);
    check("tls_byte", tx_log[0], 8'h41);

    // TPC of 0x42 while 0x41 is still busy: queued until 0x41 completes.
    iot_skip(PRT, 3'd6, 8'h41, s);
    for (int k = 0; k < 10 && tx_ack_cnt < 2; k++) tick();
    check("ovl_first_ack", tx_ack_cnt, 2);
    ticks(3);
    iot_skip(PRT, 3'd4, 8'h42, s);
    flag_seen = 1'b0;
    req_seen  = 1'b0;
    for (int k = 0; k < 80 && !req_seen; k++) begin
      if (tx_req) begin
        req_seen = 1'b1;
        check("ovl_req_after_flag", flag_seen, 1);
        check("ovl_tx_data", tx_data, 8'h42);
      end else begin
        iot_skip(PRT, 3'd1, 8'h00, s);
        if (s) flag_seen = 1'b1;
      end
    end
    check("ovl_req_seen", req_seen, 1);
    ticks(40);
    check("ovl_acks", tx_ack_cnt, 3);
    check("ovl_second_byte", tx_log[2], 8'h42);
    iot_skip(PRT, 3'd1, 8'h00, s);
    check("ovl_flag_end", s, 1);

    // Reset while RX is in R_WAIT and TX is in T_BUSY (ie cleared beforehand).
    iot_skip(KBD, 3'd5, 8'h00, s);
    iot_skip(PRT, 3'd6, 8'h55, s);
    for (int k = 0; k < 10 && tx_ack_cnt < 4; k++) tick();
    check("rst_mid_tx_ack", tx_ack_cnt, 4);
    ticks(3);
    rx_ack_cnt = 0;
    rx_q.push_back(8'h58);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (rx_req) seen = 1'b1;
      else tick();
    end
    check("rst_mid_rx_req", seen, 1);
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_rx_req_low", rx_req, 0);
    check("rst_mid_tx_req_low", tx_req, 0);
    check("rst_mid_irq_low", interrupt_req, 0);
    reset = 1'b0;
    iot_skip(KBD, 3'd1, 8'h00, s);
    check("rst_mid_kbd_flag", s, 0);
    iot_skip(PRT, 3'd1, 8'h00, s);
    check("rst_mid_prt_flag", s, 0);
    ticks(40);
    iot_skip(PRT, 3'd5, 8'h00, s);
    check("rst_mid_no_late_flag", s, 0);
    check("rst_mid_no_late_irq", interrupt_req, 0);
    check("rst_mid_no_resend", tx_ack_cnt, 4);
    check("rst_mid_no_refetch", rx_ack_cnt, 1);
    iot_skip(PRT, 3'd0, 8'h00, s);
    tick();
    check("rst_mid_ie_set", interrupt_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
